// File: rtl/lane_sync_ctrl.sv
// Receive-side lane controller: acquires symbol lock on COM runs, strips
// COM/IDLE framing once locked and forwards data bytes to the 8-to-32 demux
// in unbroken groups of four. Framing violations drop lock and pulse err.
module lane_sync_ctrl #(
    parameter logic [7:0]  COM_SYM    = 8'hBC,
    parameter logic [7:0]  IDLE_SYM   = 8'h7C,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       lane_active,
    output logic       word_start,
    output logic       err
);

    typedef enum logic [1:0] {
        LOOKING,
        COUNTING,
        LOCKED
    } state_t;

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

    state_t     state, state_n;
    logic [3:0] com_cnt, com_cnt_n;
    logic [1:0] byte_sel, byte_sel_n;
    logic [7:0] data_n;
    logic       valid_n, word_start_n, err_n;
    logic       is_com, is_idle;

    assign is_com  = (data_in == COM_SYM);
    assign is_idle = (data_in == IDLE_SYM);

    // Next-state and next-output decode for lock acquisition and framing.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_n      = state;
        com_cnt_n    = com_cnt;
        byte_sel_n   = byte_sel;
        data_n       = data_out;
        valid_n      = 1'b0;
        word_start_n = 1'b0;
        err_n        = 1'b0;

        case (state)
            LOOKING: begin
                if (valid_in && is_com) begin
                    if (LOCK_CNT == 4'd1) begin
                        state_n   = LOCKED;
                        com_cnt_n = 4'd0;
                    end else begin
                        state_n   = COUNTING;
                        com_cnt_n = 4'd1;
                    end
                end
            end

            COUNTING: begin
                if (valid_in) begin
                    if (is_com) begin
                        if (com_cnt + 4'd1 == LOCK_CNT) begin
                            state_n   = LOCKED;
                            com_cnt_n = 4'd0;
                        end else begin
                            com_cnt_n = com_cnt + 4'd1;
                        end
                    end else begin
                        state_n   = LOOKING;
                        com_cnt_n = 4'd0;
                    end
                end
            end

            LOCKED: begin
                if (valid_in && !is_com && !is_idle) begin
                    data_n       = data_in;
                    valid_n      = 1'b1;
                    word_start_n = (byte_sel == 2'd0);
                    byte_sel_n   = byte_sel + 2'd1;
                end else if (byte_sel != 2'd0) begin
                    // Framing byte or gap inside a word: the demux would
                    // otherwise see a broken word, so drop lock. The
                    // offending byte is consumed, never re-evaluated.
                    err_n      = 1'b1;
                    state_n    = LOOKING;
                    byte_sel_n = 2'd0;
                    com_cnt_n  = 4'd0;
                end
            end

            default: begin
                state_n    = LOOKING;
                com_cnt_n  = 4'd0;
                byte_sel_n = 2'd0;
            end
        endcase
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk_4f) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (!reset) begin
            state       <= LOOKING;
            com_cnt     <= 4'd0;
            byte_sel    <= 2'd0;
            data_out    <= 8'h00;
            valid_out   <= 1'b0;
            lane_active <= 1'b0;
            word_start  <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_n;
            com_cnt     <= com_cnt_n;
            byte_sel    <= byte_sel_n;
            data_out    <= data_n;
            valid_out   <= valid_n;
            lane_active <= (state_n == LOCKED);
            word_start  <= word_start_n;
            err         <= err_n;
        end
    end

endmodule

// File: tb/tb_lane_sync_ctrl.sv
// Scoreboard bench for lane_sync_ctrl: directed vectors push hand-computed
// expected outputs; a monitor pops and compares one entry per output cycle.
module tb_lane_sync_ctrl;

    logic       clk_4f = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       lane_active;
    logic       word_start;
    logic       err;

    lane_sync_ctrl dut (
        .clk_4f      (clk_4f),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .lane_active (lane_active),
        .word_start  (word_start),
        .err         (err)
    );

    always #5 clk_4f = ~clk_4f;

    typedef struct {
        int         issue;
        logic       chk_data;
        logic [7:0] data;
        logic       v;
        logic       ws;
        logic       e;
        logic       la;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] words[$];
    int          cyc    = 0;
    int          checks = 0;
    int          passed = 0;

    always @(posedge clk_4f) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: compares DUT outputs against the oldest entry issued in an
    // earlier cycle, and assembles forwarded bytes into demux words.
    initial begin : monitor
        logic [31:0] acc;
        int          n;
        exp_t        e;
        acc = 32'h0;
        n   = 0;
        forever begin
            @(posedge clk_4f);
            #2;
            while (sb.size() > 0 && sb[0].issue < cyc) begin
                e = sb.pop_front();
                check("valid_out",   {31'h0, valid_out},   {31'h0, e.v});
                check("word_start",  {31'h0, word_start},  {31'h0, e.ws});
                check("err",         {31'h0, err},         {31'h0, e.e});
                check("lane_active", {31'h0, lane_active}, {31'h0, e.la});
                if (e.chk_data) check("data_out", {24'h0, data_out}, {24'h0, e.data});
            end
            if (valid_out === 1'b1) begin
                if (word_start === 1'b1) begin
                    acc = {24'h0, data_out};
                    n   = 1;
                end else if (n > 0) begin
                    acc = acc | ({24'h0, data_out} << (8 * n));
                    n++;
                end
                if (n == 4) begin
                    words.push_back(acc);
                    n = 0;
                end
            end
        end
    end

    task automatic step(input logic r, input logic v, input logic [7:0] d,
                        input logic ev, input logic [7:0] ed, input logic ews,
                        input logic eerr, input logic ela);
        exp_t e;
        @(posedge clk_4f);
        #1;
        reset    = r;
        valid_in = v;
        data_in  = d;
        e.issue    = cyc;
        e.chk_data = ev || !r;
        e.data     = ed;
        e.v        = ev;
        e.ws       = ews;
        e.e        = eerr;
        e.la       = ela;
        sb.push_back(e);
    endtask

    task automatic com(input logic ela);
        step(1'b1, 1'b1, 8'hBC, 1'b0, 8'h00, 1'b0, 1'b0, ela);
    endtask

    task automatic lock4();
        com(1'b0); com(1'b0); com(1'b0); com(1'b1);
    endtask

    task automatic fwd(input logic [7:0] d, input logic ws);
        step(1'b1, 1'b1, d, 1'b1, d, ws, 1'b0, 1'b1);
    endtask

    task automatic drop(input logic [7:0] d);
        step(1'b1, 1'b1, d, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    logic [31:0] exp_words [3] = '{32'h44332211, 32'hA4A3A2A1, 32'hB4B3B2B1};

    initial begin
        reset    = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;

        // Reset held with COMs on the wire: nothing counted.
        repeat (3) step(1'b0, 1'b1, 8'hBC, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        lock4();
        fwd(8'h11, 1'b1); fwd(8'h22, 1'b0); fwd(8'h33, 1'b0); fwd(8'h44, 1'b0);

        // Reset mid-word: partial word discarded, no error.
        fwd(8'h01, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Three COMs (with a held gap), a non-COM breaks the run, then relock.
        com(1'b0); com(1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        com(1'b0);
        step(1'b1, 1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        lock4();

        // IDLE inside a word: violation, then four fresh COMs needed.
        fwd(8'hAA, 1'b1); fwd(8'hBB, 1'b0);
        step(1'b1, 1'b1, 8'h7C, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        lock4();

        // Framing between words is stripped, words stay contiguous.
        fwd(8'hA1, 1'b1); fwd(8'hA2, 1'b0); fwd(8'hA3, 1'b0); fwd(8'hA4, 1'b0);
        drop(8'h7C); drop(8'h7C);
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        fwd(8'hB1, 1'b1); fwd(8'hB2, 1'b0); fwd(8'hB3, 1'b0); fwd(8'hB4, 1'b0);

        // A violating COM is consumed and does not count towards relock.
        fwd(8'h01, 1'b1);
        step(1'b1, 1'b1, 8'hBC, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        lock4();

        // Gap inside a word, then reset during COUNTING clears com_cnt.
        fwd(8'h01, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        com(1'b0); com(1'b0);
        step(1'b0, 1'b1, 8'hBC, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        lock4();

        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        repeat (4) @(posedge clk_4f);
        #3;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("word_count", 32'(words.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < words.size()) check($sformatf("demux_word%0d", i), words[i], exp_words[i]);
            else check($sformatf("demux_word%0d_missing", i), 32'hDEAD_0000, exp_words[i]);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
